div_phase_gen: RTL

//  Multi-channel programmable clock-enable generator; successor to the fixed 8-slot phase divider.
//  - One free-running counter with a programmable period (div_max+1 cycles).
//  - Each of NUM_CH channels emits a one-cycle enable pulse at its own programmable phase slot.
//  - Outputs are enables for downstream pipeline stages, never gated clocks.
//  - Config changes are double-buffered and applied only at the period wrap, so no runt or missing slots.

---
 rtl/div_phase_pkg.sv | 19 +
 rtl/div_phase_gen_if.sv | 39 +++
 rtl/div_phase_chan.sv | 53 +++++
 rtl/div_phase_gen.sv | 83 ++++++++
 4 files changed

// File: rtl/div_phase_pkg.sv
// Shared types and defaults for the programmable phase-enable generator.
// Provides default widths, the reset terminal count and the config bundle.
package div_phase_pkg;

  localparam int CNT_W_DEF  = 3;
  localparam int NUM_CH_DEF = 4;

  // All-ones terminal count of width w (longest period after reset).
  function automatic logic [31:0] RST_DIV_MAX(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  typedef struct packed {
    logic [CNT_W_DEF-1:0]                 div_max;
    logic [NUM_CH_DEF-1:0][CNT_W_DEF-1:0] phase;
    logic [NUM_CH_DEF-1:0]                ch_en;
  } cfg_t;

endpackage

// File: rtl/div_phase_gen_if.sv
// Config/status bundle of div_phase_gen; slave = generator, master = driver.
// Inputs: cfg_load, div_max_in, phase_in, ch_en_in. Outputs: ph_en, wrap, cnt,
// cfg_pending, and oor when DIV_PHASE_OOR_EN is defined.
interface div_phase_gen_if
  import div_phase_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
);
  logic                    cfg_load;
  logic [CNT_W-1:0]        div_max_in;
  logic [NUM_CH*CNT_W-1:0] phase_in;
  logic [NUM_CH-1:0]       ch_en_in;
  logic [NUM_CH-1:0]       ph_en;
  logic                    wrap;
  logic [CNT_W-1:0]        cnt;
  logic                    cfg_pending;
`ifdef DIV_PHASE_OOR_EN
  logic [NUM_CH-1:0]       oor;

  modport master (
    output cfg_load, div_max_in, phase_in, ch_en_in,
    input  ph_en, wrap, cnt, cfg_pending, oor
  );
  modport slave (
    input  cfg_load, div_max_in, phase_in, ch_en_in,
    output ph_en, wrap, cnt, cfg_pending, oor
  );
`else
  modport master (
    output cfg_load, div_max_in, phase_in, ch_en_in,
    input  ph_en, wrap, cnt, cfg_pending
  );
  modport slave (
    input  cfg_load, div_max_in, phase_in, ch_en_in,
    output ph_en, wrap, cnt, cfg_pending
  );
`endif
endinterface

// File: rtl/div_phase_chan.sv
// One phase channel: active phase/enable regs, slot comparator, ph_en flop.
// Ports: clk, rst, i_apply/i_phase/i_en (shadow + apply strobe), i_cnt,
// o_ph_en; with DIV_PHASE_OOR_EN also i_div_max (active) and o_oor.
module div_phase_chan
  import div_phase_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_apply,
  input  logic [CNT_W-1:0] i_phase,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_ph_en
`ifdef DIV_PHASE_OOR_EN
  ,
  input  logic [CNT_W-1:0] i_div_max,
  output logic             o_oor
`endif
);
  logic [CNT_W-1:0] r_phase;
  logic             r_en;
  logic             r_ph_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
      r_en    <= 1'b0;
      r_ph_en <= 1'b0;
    end else begin
      // Compare uses the config active before this edge's apply.
      r_ph_en <= r_en && (i_cnt == r_phase);
      if (i_apply) begin
        r_phase <= i_phase;
        r_en    <= i_en;
      end
    end
  end

  assign o_ph_en = r_ph_en;

`ifdef DIV_PHASE_OOR_EN
  logic r_oor;

  always_ff @(posedge clk) begin
    if (rst) r_oor <= 1'b0;
    else     r_oor <= r_en && (r_phase > i_div_max);
  end

  assign o_oor = r_oor;
`endif
endmodule

// File: rtl/div_phase_gen.sv
// Multi-channel clock-enable generator: counter, shadow config, wrap-time apply.
// Ports: clk, rst (sync, active-high), bus (div_phase_gen_if.slave).
// Option DIV_PHASE_OOR_EN adds the registered out-of-range flags bus.oor.
module div_phase_gen
  import div_phase_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  div_phase_gen_if.slave bus
);
  localparam logic [CNT_W-1:0] RST_DM = CNT_W'(RST_DIV_MAX(CNT_W));

  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_dm_act;
  logic [CNT_W-1:0]        r_sh_dm;
  logic [NUM_CH*CNT_W-1:0] r_sh_ph;
  logic [NUM_CH-1:0]       r_sh_en;
  logic                    r_pend;
  logic                    r_wrap;
  logic                    w_at_max;
  logic                    w_apply;
  logic [NUM_CH-1:0]       w_ph_en;

  assign w_at_max = (r_cnt == r_dm_act);
  assign w_apply  = w_at_max && r_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dm_act <= RST_DM;
      r_sh_dm  <= RST_DM;
      r_sh_ph  <= '0;
      r_sh_en  <= '0;
      r_pend   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_cnt  <= w_at_max ? '0 : r_cnt + 1'b1;
      r_wrap <= w_at_max;
      if (w_apply) r_dm_act <= r_sh_dm;
      // A load coinciding with apply: old shadow goes active, new one waits.
      if (bus.cfg_load) begin
        r_sh_dm <= bus.div_max_in;
        r_sh_ph <= bus.phase_in;
        r_sh_en <= bus.ch_en_in;
        r_pend  <= 1'b1;
      end else if (w_apply) begin
        r_pend  <= 1'b0;
      end
    end
  end

`ifdef DIV_PHASE_OOR_EN
  logic [NUM_CH-1:0] w_oor;
  assign bus.oor = w_oor;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    div_phase_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .i_apply  (w_apply),
      .i_phase  (r_sh_ph[g*CNT_W +: CNT_W]),
      .i_en     (r_sh_en[g]),
      .i_cnt    (r_cnt),
      .o_ph_en  (w_ph_en[g])
`ifdef DIV_PHASE_OOR_EN
      ,
      .i_div_max(r_dm_act),
      .o_oor    (w_oor[g])
`endif
    );
  end

  assign bus.ph_en       = w_ph_en;
  assign bus.wrap        = r_wrap;
  assign bus.cnt         = r_cnt;
  assign bus.cfg_pending = r_pend;
endmodule
